mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
 - ADDR_W, 32, byte address width.
 - DATA_W, 64, load/store data width.
 - STARVE_MAX, 4, consecutive load/store grants allowed while fetch waits.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
 - clk  in  1  single clock, rising edge.
 - reset  in  1  synchronous, active-high.
 - if_req  in  1  fetch request.
 - if_addr  in  ADDR_W  fetch address.
 - if_rdata  out  32  instruction.
 - if_ready  out  1  fetch done pulse.
 - ls_req  in  1  load/store request.
 - ls_we  in  1  1=store.
 - ls_addr  in  ADDR_W  load/store address.
 - ls_wdata  in  DATA_W  store data.
 - ls_wstrb  in  DATA_W/8  byte enables.
 - ls_rdata  out  DATA_W  load data.
 - ls_ready  out  1  load/store done pulse.
 - mem_req  out  1  memory request.
 - mem_we  out  1  memory write.
 - mem_addr  out  ADDR_W  memory address.
 - mem_wdata  out  DATA_W  memory write data.
 - mem_wstrb  out  DATA_W/8  memory byte enables.
 - mem_ack  in  1  one-cycle completion.
 - mem_rdata  in  DATA_W  read data, valid with mem_ack.
 - busy  out  1  transaction in flight.

Function
REQ-003 FSM states SHALL be IDLE, GNT_IF, GNT_LS and DONE.
REQ-004 In IDLE, if no request is present, the FSM SHALL stay in IDLE.
REQ-005 In IDLE with any request, the arbiter SHALL grant load/store over fetch, except that when if_req=1 and starve_cnt==STARVE_MAX it SHALL grant fetch.
REQ-006 On grant at edge T, the arbiter SHALL latch the winner's address, we, wdata and wstrb, and drive mem_req=1 with those latched values from cycle T+1.
REQ-007 mem_req and all mem_* fields SHALL stay constant until the cycle mem_ack=1, inclusive.
REQ-008 Fetch grants SHALL drive mem_we=0 and mem_wstrb=0.
REQ-009 On mem_ack in cycle A:
 - the FSM SHALL enter DONE at A+1.
 - the owner's ready SHALL pulse high for exactly cycle A+1.
 - rdata SHALL be registered: if_rdata = mem_rdata[31:0]; ls_rdata = mem_rdata for loads and 0 for stores.
REQ-010 DONE SHALL last one cycle and then return to IDLE, so a request still held during the ready cycle is not re-granted; back-to-back grants SHALL occur no sooner than A+2.
REQ-011 Minimum latency (req sampled to ready) SHALL be 2 cycles plus the memory's ack delay.
REQ-012 starve_cnt SHALL increment on each load/store grant made while if_req=1, saturate at STARVE_MAX, and clear on every fetch grant.
REQ-013 Requesters SHALL hold req and fields stable until ready; changes to non-owner fields during a transaction SHALL have no effect.
REQ-014 mem_ack received in IDLE or DONE SHALL be ignored.
REQ-015 busy SHALL be 1 in GNT_IF and GNT_LS, and 0 otherwise.
REQ-016 Simultaneous if_req and ls_req SHALL resolve per REQ-005 within the same cycle; the loser waits with no ready pulse.

Reset
REQ-017 With reset=1 at a clock edge, the block SHALL enter IDLE, clear starve_cnt, and drive all outputs to 0, including during an in-flight transaction.
REQ-018 An abandoned in-flight transaction SHALL generate no ready pulse, and any later mem_ack SHALL be ignored.

Structure
REQ-019 A shared package rv_mem_pkg SHALL hold the state enum (IDLE, GNT_IF, GNT_LS, DONE) and the ADDR_W/DATA_W defaults.
REQ-020 The starvation counter SHALL be the single sub-module arb_starve_counter, with ports inc, clr and sat.
REQ-021 All state SHALL be in one clocked process, and the implementation SHALL contain no latches.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
 - Lone fetch of addr 0x10, memory ack 1 cycle after mem_req, mem_rdata 0x00100093 -> if_ready pulses once with if_rdata=0x00100093, 3 cycles after request; busy high for 2 cycles.
 - if_req and ls_req (load, addr 0x20) asserted together -> LS granted first; ls_ready before if_ready; then fetch completes with no re-grant of the load.
 - Store of 0x64 to addr 0x20 with wstrb 0xFF -> mem_we=1, mem_wdata=0x64 held stable across 3 wait cycles; ls_rdata=0 with ls_ready.
 - ls_req held continuously with if_req pending, STARVE_MAX=4 -> exactly 4 LS grants, then a fetch grant, then the counter clears.
 - reset asserted in GNT_LS before ack -> next cycle all outputs 0; a late mem_ack produces no ls_ready.
 - Spurious mem_ack in IDLE -> no ready pulse and no state change.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the instruction/data memory port arbiter.
//   - Default address/data widths and starvation limit.
//   - Arbiter FSM state encoding.
//   - cnt_width(): width needed to hold a counter value 0..max_val.
package rv_mem_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: next-state logic for the fetch starvation counter.
// The count register itself lives in the arbiter's single clocked process; this
// block only decides the next value and flags saturation.
//   cnt     in   current count
//   inc     in   load/store grant made while fetch was waiting
//   clr     in   fetch grant (clear wins over inc)
//   cnt_nxt out  next count, saturating at STARVE_MAX
//   sat     out  current count has reached STARVE_MAX
module arb_starve_counter
  import rv_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned CNT_W      = cnt_width(STARVE_MAX)
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sat
);

  assign sat = (cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && !sat) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (if_*) and
// load/store (ls_*). Load/store has priority unless fetch has been passed over
// STARVE_MAX times in a row. One transaction at a time; a DONE cycle follows each
// completion so a request still held during its ready pulse is not re-granted.
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             fetch request; if_rdata/if_ready result
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_wstrb          load/store request; ls_rdata/ls_ready result
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb        memory request, held until mem_ack
//   mem_ack/mem_rdata          memory completion (rdata valid with ack)
//   busy                       a granted transaction is in flight
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [31:0]         if_rdata,
  output logic                if_ready,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

  arb_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             starve_sat;
  logic             grant_if;
  logic             grant_ls;

  // Fetch wins only when load/store is absent or fetch has been starved long enough.
  always_comb begin
    grant_if = (state == IDLE) && if_req && (!ls_req || starve_sat);
    grant_ls = (state == IDLE) && ls_req && !grant_if;
  end

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .cnt     (starve_cnt),
    .inc     (grant_ls && if_req),
    .clr     (grant_if),
    .cnt_nxt (starve_nxt),
    .sat     (starve_sat)
  );

  assign busy = (state == GNT_IF) || (state == GNT_LS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_ready   <= 1'b0;
      ls_ready   <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if_ready   <= 1'b0;
      ls_ready   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state     <= GNT_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end else if (grant_ls) begin
            state     <= GNT_LS;
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wstrb <= ls_wstrb;
          end
        end
        GNT_IF, GNT_LS: begin
          // mem_* fields stay latched; only mem_req drops once the ack arrives.
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (state == GNT_IF) begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata[31:0];
            end else begin
              ls_ready <= 1'b1;
              ls_rdata <= mem_we ? '0 : mem_rdata;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run, all
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STARVE_MAX = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic [31:0]         if_rdata;
  logic                if_ready;
  logic                ls_req;
  logic                ls_we;
  logic [ADDR_W-1:0]   ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic [DATA_W/8-1:0] ls_wstrb;
  logic [DATA_W-1:0]   ls_rdata;
  logic                ls_ready;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wstrb  (ls_wstrb),
    .ls_rdata  (ls_rdata),
    .ls_ready  (ls_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the port, whether we are in the post-completion
  // cool-down cycle, how often fetch has been passed over, and what the outputs
  // must look like in the current cycle.
  int                  m_owner = 0;  // 0 none, 1 fetch, 2 load/store
  bit                  m_done  = 1'b0;
  int                  m_starve = 0;
  logic                e_mem_req = 1'b0;
  logic                e_we = 1'b0;
  logic [ADDR_W-1:0]   e_addr = '0;
  logic [DATA_W-1:0]   e_wdata = '0;
  logic [DATA_W/8-1:0] e_wstrb = '0;
  logic                e_if_ready = 1'b0;
  logic                e_ls_ready = 1'b0;
  logic [31:0]         e_if_rdata = '0;
  logic [DATA_W-1:0]   e_ls_rdata = '0;
  logic                e_zero = 1'b0;
  logic                e_busy;

  assign e_busy = (m_owner != 0);

  always @(posedge clk) begin
    e_zero     <= 1'b0;
    e_if_ready <= 1'b0;
    e_ls_ready <= 1'b0;
    if (reset) begin
      m_owner    <= 0;
      m_done     <= 1'b0;
      m_starve   <= 0;
      e_mem_req  <= 1'b0;
      e_if_rdata <= '0;
      e_ls_rdata <= '0;
      e_zero     <= 1'b1;
    end else if (m_owner != 0) begin
      if (mem_ack) begin
        if (m_owner == 1) begin
          e_if_ready <= 1'b1;
          e_if_rdata <= mem_rdata[31:0];
        end else begin
          e_ls_ready <= 1'b1;
          e_ls_rdata <= e_we ? '0 : mem_rdata;
        end
        m_owner   <= 0;
        m_done    <= 1'b1;
        e_mem_req <= 1'b0;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (if_req && (!ls_req || m_starve == STARVE_MAX)) begin
      m_owner   <= 1;
      m_starve  <= 0;
      e_mem_req <= 1'b1;
      e_we      <= 1'b0;
      e_addr    <= if_addr;
      e_wdata   <= '0;
      e_wstrb   <= '0;
    end else if (ls_req) begin
      m_owner   <= 2;
      if (if_req && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
      e_mem_req <= 1'b1;
      e_we      <= ls_we;
      e_addr    <= ls_addr;
      e_wdata   <= ls_wdata;
      e_wstrb   <= ls_wstrb;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, e_busy);
      chk("mem_req", mem_req, e_mem_req);
      chk("if_ready", if_ready, e_if_ready);
      chk("ls_ready", ls_ready, e_ls_ready);
      if (e_mem_req) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wstrb", mem_wstrb, e_wstrb);
        if (m_owner == 2) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_if_ready) chk("if_rdata", if_rdata, e_if_rdata);
      if (e_ls_ready) chk("ls_rdata", ls_rdata, e_ls_rdata);
      if (e_zero) begin
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int  busy_cnt;
  int  t;
  bit  got_f;
  bit  if_done;
  bit  ls_done;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = '0; ls_wdata = '0; ls_wstrb = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    cmp_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_if_ready", if_ready, 0);
    reset = 1'b0;
    tick();

    // Lone fetch, ack one cycle after mem_req.
    if_req = 1'b1; if_addr = 32'h10; busy_cnt = 0;
    tick();
    busy_cnt += int'(busy);
    chk("d1_mem_req", mem_req, 1);
    chk("d1_mem_addr", mem_addr, 32'h10);
    chk("d1_mem_we", mem_we, 0);
    chk("d1_mem_wstrb", mem_wstrb, 0);
    tick();
    busy_cnt += int'(busy);
    chk("d1_req_held", mem_req, 1);
    chk("d1_no_early_ready", if_ready, 0);
    mem_ack = 1'b1; mem_rdata = 64'hdead_beef_0010_0093;
    tick();
    busy_cnt += int'(busy);
    mem_ack = 1'b0;
    chk("d1_if_ready", if_ready, 1);
    chk("d1_if_rdata", if_rdata, 32'h0010_0093);
    chk("d1_model_ready", e_if_ready, 1);
    tick();
    if_req = 1'b0;
    busy_cnt += int'(busy);
    chk("d1_single_pulse", if_ready, 0);
    chk("d1_busy_cycles", busy_cnt, 2);
    tick();

    // Simultaneous fetch and load: load first, fetch after, load not re-granted.
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_wdata = '0; ls_wstrb = '0;
    tick();
    chk("d2_ls_first_addr", mem_addr, 32'h20);
    chk("d2_ls_first_we", mem_we, 0);
    mem_ack = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    tick();
    mem_ack = 1'b0;
    chk("d2_ls_ready", ls_ready, 1);
    chk("d2_ls_rdata", ls_rdata, 64'h1122_3344_5566_7788);
    chk("d2_if_waits", if_ready, 0);
    tick();
    ls_req = 1'b0;
    chk("d2_gap", mem_req, 0);
    tick();
    chk("d2_if_grant", mem_req, 1);
    chk("d2_if_addr", mem_addr, 32'h40);
    mem_ack = 1'b1; mem_rdata = 64'h0000_0000_0000_0013;
    tick();
    mem_ack = 1'b0;
    chk("d2_if_ready", if_ready, 1);
    chk("d2_if_rdata", if_rdata, 32'h13);
    chk("d2_no_ls_regrant", ls_ready, 0);
    tick();
    if_req = 1'b0;
    tick();

    // Store with three wait cycles before ack.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 64'h64; ls_wstrb = 8'hff;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if_addr = $urandom;
      chk("d3_mem_req", mem_req, 1);
      chk("d3_mem_we", mem_we, 1);
      chk("d3_mem_wdata", mem_wdata, 64'h64);
      chk("d3_mem_wstrb", mem_wstrb, 8'hff);
      chk("d3_mem_addr", mem_addr, 32'h20);
      if (k == 4) begin
        mem_ack = 1'b1; mem_rdata = 64'hffff_ffff_ffff_ffff;
      end
    end
    tick();
    mem_ack = 1'b0;
    chk("d3_ls_ready", ls_ready, 1);
    chk("d3_ls_rdata_store", ls_rdata, 0);
    tick();
    ls_req = 1'b0;
    tick();

    // Starvation: ls_req and if_req both held; fetch every fifth grant.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      t = 0;
      while (!mem_req && t < 8) begin
        tick();
        t++;
      end
      if (!mem_req) begin
        chk("d4_grant_timeout", mem_req, 1);
        break;
      end
      got_f = (mem_addr == 32'h200);
      chk("d4_grant_kind", got_f, (g == 4 || g == 9));
      mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
      tick();
      mem_ack = 1'b0;
    end
    tick();
    ls_req = 1'b0; if_req = 1'b0;
    tick();
    tick();

    // Reset while a load is granted, then a late ack.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h30;
    tick();
    chk("d5_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; ls_req = 1'b0;
    chk("d5_busy0", busy, 0);
    chk("d5_mem_req0", mem_req, 0);
    chk("d5_mem_addr0", mem_addr, 0);
    chk("d5_mem_we0", mem_we, 0);
    chk("d5_mem_wdata0", mem_wdata, 0);
    chk("d5_mem_wstrb0", mem_wstrb, 0);
    chk("d5_if_ready0", if_ready, 0);
    chk("d5_ls_ready0", ls_ready, 0);
    chk("d5_if_rdata0", if_rdata, 0);
    chk("d5_ls_rdata0", ls_rdata, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("d5_late_ack", ls_ready, 0);
    tick();
    chk("d5_late_ack2", ls_ready, 0);

    // Spurious ack in IDLE, then a normal fetch still works.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("d6_no_if_ready", if_ready, 0);
      chk("d6_no_ls_ready", ls_ready, 0);
      chk("d6_idle", busy, 0);
      tick();
    end
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    chk("d6_fetch_grant", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 64'h0000_0000_0000_0073;
    tick();
    mem_ack = 1'b0;
    chk("d6_fetch_ready", if_ready, 1);
    tick();
    if_req = 1'b0;
    tick();

    // Randomized traffic with occasional resets and spurious acks.
    if_done = 1'b0;
    ls_done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 249) == 0);
      if (if_req) begin
        if (if_done) begin
          if_req  = $urandom_range(0, 1) == 1;
          if_addr = $urandom & 32'hffff_fffc;
        end
      end else begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = $urandom & 32'hffff_fffc;
      end
      if_done = e_if_ready;
      if (ls_req) begin
        if (ls_done) begin
          ls_req   = $urandom_range(0, 1) == 1;
          ls_we    = $urandom_range(0, 1) == 1;
          ls_addr  = $urandom & 32'hffff_fff8;
          ls_wdata = {$urandom, $urandom};
          ls_wstrb = 8'($urandom);
        end
      end else begin
        ls_req   = ($urandom_range(0, 1) == 0);
        ls_we    = $urandom_range(0, 1) == 1;
        ls_addr  = $urandom & 32'hffff_fff8;
        ls_wdata = {$urandom, $urandom};
        ls_wstrb = 8'($urandom);
      end
      ls_done   = e_ls_ready;
      mem_ack   = e_mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = {$urandom, $urandom};
    end
    reset = 1'b0; if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
